comp4_resp_checker: RTL and testbench
=====================================

# comp4_resp_checker

- Synthesizable response checker for the 4-bit magnitude comparator: the receiving end of the comparator test path.
- Samples each applied operand pair (a, b) together with the comparator's l/g/e outputs and checks them against a golden compare.
- Counts vectors and mismatches, and captures the first failing vector.
- Reports pass/fail once a programmed number of vectors has been checked; sits between the comparator instance and the on-chip status/debug registers.

## Interface
Parameters:
- N_VECTORS, 15, number of vectors per run (1..2^CNT_W-1)
- CNT_W, 8, width of the vector and error counters
- TIMEOUT, 255, idle-cycle limit in RUN (used only with COMP4_CHK_TIMEOUT_EN)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a run
- vld  in  1  a, b, l, g, e valid this cycle
- a  in  4  operand A as applied to the comparator
- b  in  4  operand B as applied to the comparator
- l  in  1  comparator "A<B" output
- g  in  1  comparator "A>B" output
- e  in  1  comparator "A==B" output
- busy  out  1  high in RUN
- done  out  1  high in DONE
- pass  out  1  valid when done; 1 = zero errors and no timeout
- vec_cnt  out  CNT_W  vectors checked in current/last run
- err_cnt  out  CNT_W  mismatching vectors, saturating
- fail_vld  out  1  first-failure capture valid
- fail_a, fail_b  out  4 each  operands of first failure
- fail_lge  out  3  {l,g,e} seen at first failure
- timeout  out  1  run ended by watchdog

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE: start -> RUN.
  - RUN: vec_cnt reaches N_VECTORS -> DONE; watchdog expiry -> DONE.
  - DONE: start -> RUN.
- Entering RUN clears vec_cnt, err_cnt, fail_vld, fail_a/b/lge, timeout, pass.
- start while in RUN is ignored.
- vld in IDLE or DONE is ignored; no counter or capture changes.
- Golden values: exp = {a<b, a>b, a==b}, unsigned 4-bit compare.
- A vector mismatches when {l,g,e} != exp. This includes non-one-hot responses (000, 011, 111, etc.).
- Per vld in RUN:
  - vec_cnt +1.
  - On mismatch, err_cnt +1, saturating at 2^CNT_W-1.
  - On mismatch with fail_vld=0, capture a, b, {l,g,e} and set fail_vld. Later failures do not overwrite the capture.
- pass = (err_cnt==0) && !timeout. It is registered on the DONE transition and held until the next start.
- DONE holds all results stable until start or rst.

## Timing
- Reset: state=IDLE; busy=0, done=0, pass=0, vec_cnt=0, err_cnt=0, fail_vld=0, fail_a=0, fail_b=0, fail_lge=0, timeout=0.
- rst asserted mid-run aborts immediately to the reset state. No partial results are kept.
- start sampled at edge k: busy=1 from k+1. The first vld accepted is at edge k+1.
- vld with data sampled at edge n: vec_cnt, err_cnt and capture are updated after edge n (one-cycle latency).
- The last vector (vec_cnt reaching N_VECTORS) sampled at edge n: state=DONE, done=1, busy=0, and pass is valid after edge n. pass includes that last vector's result.
- vld beyond N_VECTORS is ignored, because the block is already in DONE.
- start and vld in the same cycle from IDLE/DONE: start wins; that vld is not checked.
- Back-to-back vld every cycle is supported; there is no backpressure.

## Configuration
- COMP4_CHK_TIMEOUT_EN defined:
  - In RUN, a CNT_W-independent idle counter counts cycles with vld=0 and resets on each vld.
  - When it reaches TIMEOUT, the next edge sets timeout=1 and enters DONE with pass=0. vec_cnt and err_cnt are left as they are.
- COMP4_CHK_TIMEOUT_EN not defined:
  - No idle counter is built. timeout is tied to 0.
  - RUN waits indefinitely for N_VECTORS vectors.

## Test plan
- Correct responses: reset, start, then 15 vectors with correct l/g/e: (1,2..6) -> l=1; (5,0..4) -> g=1; (1,1)..(5,5) -> e=1. Required: done=1, pass=1, vec_cnt=15, err_cnt=0, fail_vld=0.
- Single wrong answer: same run, but (5,3) answered {l,g,e}=100. Required: err_cnt=1, pass=0, fail_a=5, fail_b=3, fail_lge=100.
- Non-one-hot and first-failure hold:
  - Vector (4,4) answered 011, later vector (2,2) answered 000.
  - Required: err_cnt=2; capture stays a=4, b=4, lge=011.
- start ignored in RUN: pulse start again after 7 vectors. Required: vec_cnt continues to 15; no counter clear.
- Reset mid-run: assert rst after 9 vectors with 1 error. Required: all outputs 0, state IDLE. A subsequent clean run gives pass=1.
- Watchdog (macro defined, TIMEOUT=10):
  - Stop vld after 4 vectors.
  - Required: DONE 10 idle cycles later, timeout=1, pass=0, vec_cnt=4.
  - Without the macro, the block stays busy=1.

Source files
------------

// File: rtl/comp4_resp_checker_if.sv
// Bus between the comparator test path and comp4_resp_checker: applied vector,
// comparator response, and run status/first-failure capture.
interface comp4_resp_checker_if #(
    parameter int unsigned CNT_W = 8
);
    logic             start;
    logic             vld;
    logic [3:0]       a;
    logic [3:0]       b;
    logic             l;
    logic             g;
    logic             e;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] vec_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic             fail_vld;
    logic [3:0]       fail_a;
    logic [3:0]       fail_b;
    logic [2:0]       fail_lge;
    logic             timeout;

    modport master (
        output start, vld, a, b, l, g, e,
        input  busy, done, pass, vec_cnt, err_cnt,
               fail_vld, fail_a, fail_b, fail_lge, timeout
    );

    modport slave (
        input  start, vld, a, b, l, g, e,
        output busy, done, pass, vec_cnt, err_cnt,
               fail_vld, fail_a, fail_b, fail_lge, timeout
    );
endinterface

// File: rtl/comp4_resp_checker.sv
// Response checker for the 4-bit magnitude comparator: golden compare, vector and
// error counting, first-failure capture. Optional watchdog: define COMP4_CHK_TIMEOUT_EN.
module comp4_resp_checker #(
    parameter int unsigned N_VECTORS = 15,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned TIMEOUT   = 255
) (
    input logic                clk,
    input logic                rst,
    comp4_resp_checker_if.slave io
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic [CNT_W-1:0] vec_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic             fail_vld;
    logic [3:0]       fail_a;
    logic [3:0]       fail_b;
    logic [2:0]       fail_lge;
    logic             timeout_q;

    logic [2:0]       exp_lge;
    logic [2:0]       got_lge;
    logic             mis;
    logic [CNT_W-1:0] vec_nxt;
    logic [CNT_W-1:0] err_nxt;
    logic             last;
    logic             wd_fire;

    // Golden compare of the applied vector and next counter values
    always_comb begin
        exp_lge = {io.a < io.b, io.a > io.b, io.a == io.b};
        got_lge = {io.l, io.g, io.e};
        mis     = (got_lge != exp_lge);
        vec_nxt = vec_cnt + CNT_W'(1);
        err_nxt = (mis && (err_cnt != '1)) ? err_cnt + CNT_W'(1) : err_cnt;
        last    = (vec_nxt == CNT_W'(N_VECTORS));
    end

`ifdef COMP4_CHK_TIMEOUT_EN
    localparam int unsigned IDLE_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

    logic [IDLE_W-1:0] idle_cnt;

    // Idle-cycle watchdog: restarts on every accepted vector and outside RUN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if ((state != S_RUN) || io.vld) begin
            idle_cnt <= '0;
        end else if (!wd_fire) begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
        end
    end

    assign wd_fire = (idle_cnt == IDLE_W'(TIMEOUT)) && !io.vld;
`else
    // No watchdog: TIMEOUT has no effect and the run waits for every vector
    assign wd_fire = 1'b0 & (TIMEOUT > 0);
`endif

    // Run control FSM with all results registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            vec_cnt   <= '0;
            err_cnt   <= '0;
            fail_vld  <= 1'b0;
            fail_a    <= '0;
            fail_b    <= '0;
            fail_lge  <= '0;
            timeout_q <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (io.start) begin
                        state     <= S_RUN;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        pass_q    <= 1'b0;
                        vec_cnt   <= '0;
                        err_cnt   <= '0;
                        fail_vld  <= 1'b0;
                        fail_a    <= '0;
                        fail_b    <= '0;
                        fail_lge  <= '0;
                        timeout_q <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (io.vld) begin
                        vec_cnt <= vec_nxt;
                        err_cnt <= err_nxt;
                        if (mis && !fail_vld) begin
                            fail_vld <= 1'b1;
                            fail_a   <= io.a;
                            fail_b   <= io.b;
                            fail_lge <= got_lge;
                        end
                        if (last) begin
                            state  <= S_DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            pass_q <= (err_nxt == '0);
                        end
                    end else if (wd_fire) begin
                        state     <= S_DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        pass_q    <= 1'b0;
                        timeout_q <= 1'b1;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign io.busy     = busy_q;
    assign io.done     = done_q;
    assign io.pass     = pass_q;
    assign io.vec_cnt  = vec_cnt;
    assign io.err_cnt  = err_cnt;
    assign io.fail_vld = fail_vld;
    assign io.fail_a   = fail_a;
    assign io.fail_b   = fail_b;
    assign io.fail_lge = fail_lge;
    assign io.timeout  = timeout_q;
endmodule

// File: tb/tb_comp4_resp_checker.sv
// Self-checking bench for comp4_resp_checker: directed test-plan runs plus
// randomized runs against a per-vector behavioural model.
module tb_comp4_resp_checker;
    localparam int unsigned NV    = 15;
    localparam int unsigned CW    = 8;
    localparam int unsigned TO    = 10;
    localparam int          MAXC  = 255;

    logic clk;
    logic rst;

    comp4_resp_checker_if #(.CNT_W(CW)) bus ();

    comp4_resp_checker #(
        .N_VECTORS (NV),
        .CNT_W     (CW),
        .TIMEOUT   (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    always #5 clk = ~clk;

    int n_checks;
    int n_errors;

    // Reference model: run status as seen from outside
    bit         m_busy, m_done, m_pass, m_fvld, m_to;
    int         m_vec, m_err, m_idle;
    logic [3:0] m_fa, m_fb;
    logic [2:0] m_flge;

    int tv_a [NV];
    int tv_b [NV];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] gold(input int a, input int b);
        return {(a < b), (a > b), (a == b)};
    endfunction

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_pass = 0; m_fvld = 0; m_to = 0;
        m_vec = 0; m_err = 0; m_idle = 0;
        m_fa = '0; m_fb = '0; m_flge = '0;
    endtask

    task automatic model_edge(input bit s, input bit v, input int a, input int b,
                              input logic [2:0] lge);
        if (s && !m_busy) begin
            model_reset();
            m_busy = 1;
        end else if (m_busy) begin
            if (v) begin
                m_idle = 0;
                m_vec++;
                if (lge != gold(a, b)) begin
                    if (m_err < MAXC) m_err++;
                    if (!m_fvld) begin
                        m_fvld = 1; m_fa = 4'(a); m_fb = 4'(b); m_flge = lge;
                    end
                end
                if (m_vec == NV) begin
                    m_busy = 0; m_done = 1; m_pass = (m_err == 0);
                end
            end else begin
                m_idle++;
`ifdef COMP4_CHK_TIMEOUT_EN
                if (m_idle > TO) begin
                    m_busy = 0; m_done = 1; m_pass = 0; m_to = 1;
                end
`endif
            end
        end
    endtask

    task automatic check_all();
        chk("busy",     32'(bus.busy),     32'(m_busy));
        chk("done",     32'(bus.done),     32'(m_done));
        chk("pass",     32'(bus.pass),     32'(m_pass));
        chk("vec_cnt",  32'(bus.vec_cnt),  32'(m_vec));
        chk("err_cnt",  32'(bus.err_cnt),  32'(m_err));
        chk("fail_vld", 32'(bus.fail_vld), 32'(m_fvld));
        chk("fail_a",   32'(bus.fail_a),   32'(m_fa));
        chk("fail_b",   32'(bus.fail_b),   32'(m_fb));
        chk("fail_lge", 32'(bus.fail_lge), 32'(m_flge));
        chk("timeout",  32'(bus.timeout),  32'(m_to));
    endtask

    task automatic step(input bit s, input bit v, input int a, input int b,
                        input logic [2:0] lge);
        @(negedge clk);
        bus.start = s;
        bus.vld   = v;
        bus.a     = 4'(a);
        bus.b     = 4'(b);
        {bus.l, bus.g, bus.e} = lge;
        @(posedge clk);
        model_edge(s, v, a, b, lge);
        #1;
        check_all();
    endtask

    task automatic send(input int a, input int b, input logic [2:0] lge);
        step(0, 1, a, b, lge);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 3'b000);
    endtask

    task automatic start_run();
        step(1, 0, 0, 0, 3'b000);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        clk = 0;
        rst = 1;
        n_checks = 0;
        n_errors = 0;
        bus.start = 0; bus.vld = 0; bus.a = '0; bus.b = '0;
        bus.l = 0; bus.g = 0; bus.e = 0;
        model_reset();

        for (int i = 0; i < 5; i++) begin tv_a[i]      = 1; tv_b[i]      = i + 2; end
        for (int i = 0; i < 5; i++) begin tv_a[5 + i]  = 5; tv_b[5 + i]  = i;     end
        for (int i = 0; i < 5; i++) begin tv_a[10 + i] = i + 1; tv_b[10 + i] = i + 1; end

        #12;
        check_all();
        do_reset();

        // Correct responses
        start_run();
        for (int i = 0; i < NV; i++) send(tv_a[i], tv_b[i], gold(tv_a[i], tv_b[i]));
        chk("t1_done", 32'(bus.done), 1);
        chk("t1_pass", 32'(bus.pass), 1);
        chk("t1_vec",  32'(bus.vec_cnt), 15);
        chk("t1_err",  32'(bus.err_cnt), 0);
        chk("t1_fvld", 32'(bus.fail_vld), 0);
        send(3, 3, 3'b000);
        idle();

        // Single wrong answer at (5,3), restarted with start+vld (start wins)
        step(1, 1, 7, 7, 3'b111);
        for (int i = 0; i < NV; i++)
            send(tv_a[i], tv_b[i], (i == 8) ? 3'b100 : gold(tv_a[i], tv_b[i]));
        chk("t2_err",  32'(bus.err_cnt), 1);
        chk("t2_pass", 32'(bus.pass), 0);
        chk("t2_fa",   32'(bus.fail_a), 5);
        chk("t2_fb",   32'(bus.fail_b), 3);
        chk("t2_flge", 32'(bus.fail_lge), 32'(3'b100));

        // Non-one-hot responses, first failure held (reverse order: (4,4) before (2,2))
        start_run();
        for (int i = NV - 1; i >= 0; i--) begin
            logic [2:0] r;
            r = gold(tv_a[i], tv_b[i]);
            if (i == 13) r = 3'b011;
            if (i == 11) r = 3'b000;
            send(tv_a[i], tv_b[i], r);
        end
        chk("t3_err",  32'(bus.err_cnt), 2);
        chk("t3_fa",   32'(bus.fail_a), 4);
        chk("t3_fb",   32'(bus.fail_b), 4);
        chk("t3_flge", 32'(bus.fail_lge), 32'(3'b011));

        // start ignored in RUN
        start_run();
        for (int i = 0; i < 7; i++) send(tv_a[i], tv_b[i], gold(tv_a[i], tv_b[i]));
        start_run();
        chk("t4_vec7", 32'(bus.vec_cnt), 7);
        for (int i = 7; i < NV; i++) send(tv_a[i], tv_b[i], gold(tv_a[i], tv_b[i]));
        chk("t4_vec",  32'(bus.vec_cnt), 15);
        chk("t4_done", 32'(bus.done), 1);

        // Reset mid-run, then a clean run
        start_run();
        for (int i = 0; i < 9; i++)
            send(tv_a[i], tv_b[i], (i == 2) ? 3'b010 : gold(tv_a[i], tv_b[i]));
        chk("t5_err_pre", 32'(bus.err_cnt), 1);
        do_reset();
        chk("t5_busy", 32'(bus.busy), 0);
        chk("t5_vec",  32'(bus.vec_cnt), 0);
        chk("t5_err",  32'(bus.err_cnt), 0);
        send(1, 2, 3'b000);
        start_run();
        for (int i = 0; i < NV; i++) send(tv_a[i], tv_b[i], gold(tv_a[i], tv_b[i]));
        chk("t5_pass", 32'(bus.pass), 1);

        // Watchdog / indefinite wait
        start_run();
        for (int i = 0; i < 4; i++) send(tv_a[i], tv_b[i], gold(tv_a[i], tv_b[i]));
`ifdef COMP4_CHK_TIMEOUT_EN
        for (int i = 0; i < int'(TO); i++) idle();
        chk("t6_busy_pre", 32'(bus.busy), 1);
        idle();
        chk("t6_done", 32'(bus.done), 1);
        chk("t6_to",   32'(bus.timeout), 1);
        chk("t6_pass", 32'(bus.pass), 0);
        chk("t6_vec",  32'(bus.vec_cnt), 4);
`else
        for (int i = 0; i < 20; i++) idle();
        chk("t6_busy", 32'(bus.busy), 1);
        chk("t6_to",   32'(bus.timeout), 0);
`endif
        for (int i = 4; i < NV; i++) send(tv_a[i], tv_b[i], gold(tv_a[i], tv_b[i]));
        chk("t6_done_end", 32'(bus.done), 1);

        // Randomized runs
        for (int run = 0; run < 25; run++) begin
            int n_sent;
            step(1, $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 15),
                 3'($urandom_range(0, 7)));
            n_sent = 0;
            while (n_sent < int'(NV) + 2) begin
                int a, b, gap;
                logic [2:0] r;
                a = $urandom_range(0, 15);
                b = ($urandom_range(0, 3) == 0) ? a : $urandom_range(0, 15);
                r = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : gold(a, b);
                gap = $urandom_range(0, 2);
                for (int k = 0; k < gap; k++) begin
                    if ($urandom_range(0, 9) == 0) start_run();
                    else idle();
                end
                send(a, b, r);
                n_sent++;
            end
            idle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
